// File: rtl/sm_eth_rx_pkg.sv
// Shared types and constants for the 10BASE-T receive path.
// CRC constants are consumed only when SM_ETH_RX_CRC_EN is defined.
package sm_eth_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_HOLD,
        ST_SKIP
    } rx_state_e;

    localparam logic [7:0]  PRE_BYTE    = 8'h55;
    localparam logic [7:0]  SFD_BYTE    = 8'hD5;
    localparam logic [1:0]  SFD_TAIL    = SFD_BYTE[7:6];

    localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

    // Serial CRC-32, bits fed in wire order (LSB of each byte first)
    function automatic logic [31:0] crc_step(
        input logic [31:0] c,
        input logic        b
    );
        return {c[30:0], 1'b0} ^ ((c[31] ^ b) ? CRC_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/sm_manchester_dec.sv
// Manchester bit recovery: line synchronizer, mid-bit edge
// qualification timer and carrier tracking.
module sm_manchester_dec #(
    parameter int OVERSAMPLE = 8,
    parameter int IDLE_TO    = 12,
    parameter int POLARITY   = 0
) (
    input  logic eth_clk,
    input  logic eth_rstn,
    input  logic Rxd,
    output logic bit_valid,
    output logic rx_bit,
    output logic carrier,
    output logic carrier_start,
    output logic carrier_end
);

    localparam int TMAX = (IDLE_TO > OVERSAMPLE) ? IDLE_TO : OVERSAMPLE;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] T_MID  = TW'(3 * OVERSAMPLE / 4);
    localparam logic [TW-1:0] T_IDLE = TW'(IDLE_TO);
    localparam logic [TW-1:0] T_SAT  = TW'(TMAX);
    localparam logic          POL    = (POLARITY != 0);

    logic          s1, s2, s3;
    logic [TW-1:0] timer;
    logic          edge_det;
    logic          acc;

    assign edge_det      = s2 ^ s3;
    // Edges too close to the last mid-bit edge are bit boundaries
    assign acc           = edge_det && (!carrier || timer >= T_MID);
    assign carrier_start = acc && !carrier;
    assign carrier_end   = carrier && !acc && timer >= T_IDLE;

    always_ff @(posedge eth_clk or negedge eth_rstn) begin
        if (!eth_rstn) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            timer     <= '0;
            carrier   <= 1'b0;
            bit_valid <= 1'b0;
            rx_bit    <= 1'b0;
        end else begin
            s1        <= Rxd;
            s2        <= s1;
            s3        <= s2;
            bit_valid <= acc;
            if (acc) begin
                timer   <= '0;
                carrier <= 1'b1;
                rx_bit  <= s2 ^ POL;
            end else begin
                if (timer != T_SAT)
                    timer <= timer + TW'(1);
                if (carrier_end)
                    carrier <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sm_eth_rx.sv
// 10BASE-T receive: preamble/SFD hunt, frame buffer, host handshake.
// Optional FCS check enabled by defining SM_ETH_RX_CRC_EN.
module sm_eth_rx
    import sm_eth_rx_pkg::*;
#(
    parameter int OVERSAMPLE = 8,
    parameter int IDLE_TO    = 12,
    parameter int MIN_PRE    = 16,
    parameter int DEPTH      = 128,
    parameter int POLARITY   = 0
) (
    input  logic                     eth_clk,
    input  logic                     eth_rstn,
    input  logic                     Rxd,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [7:0]               rd_data,
    output logic                     frame_ready,
    output logic [$clog2(DEPTH):0]   frame_len,
    output logic                     frame_err,
    output logic                     crc_ok,
    input  logic                     rx_ack,
    output logic [7:0]               drop_cnt,
    output logic                     Led_Rx
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(MIN_PRE + 1);

    logic          bit_valid, rx_bit;
    logic          carrier, carrier_start, carrier_end;
    rx_state_e     state, state_nxt;
    logic [PW-1:0] pre_cnt;
    logic          prev_bit;
    logic [7:0]    shreg;
    logic [2:0]    bit_cnt;
    logic [AW:0]   wr_ptr;
    logic          ovf;
    logic [7:0]    byte_nxt;
    logic          byte_done;
    logic          sfd_hit;
    logic          err_nxt;
    logic [7:0]    mem [DEPTH];

    sm_manchester_dec #(
        .OVERSAMPLE (OVERSAMPLE),
        .IDLE_TO    (IDLE_TO),
        .POLARITY   (POLARITY)
    ) u_dec (
        .eth_clk       (eth_clk),
        .eth_rstn      (eth_rstn),
        .Rxd           (Rxd),
        .bit_valid     (bit_valid),
        .rx_bit        (rx_bit),
        .carrier       (carrier),
        .carrier_start (carrier_start),
        .carrier_end   (carrier_end)
    );

    assign byte_nxt  = {rx_bit, shreg[7:1]};
    assign byte_done = (state == ST_DATA) && bit_valid && (bit_cnt == 3'd7);
    assign sfd_hit   = bit_valid && ({prev_bit, rx_bit} == SFD_TAIL)
                       && (pre_cnt >= PW'(MIN_PRE));
    assign err_nxt   = ovf || (bit_cnt != 3'd0) || (wr_ptr == '0);

    assign frame_ready = (state == ST_HOLD);
    assign Led_Rx      = ~carrier;

    always_ff @(posedge eth_clk or negedge eth_rstn) begin
        if (!eth_rstn) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (bit_valid) state_nxt = ST_PRE;
            ST_PRE: begin
                if (carrier_end)  state_nxt = ST_IDLE;
                else if (sfd_hit) state_nxt = ST_DATA;
            end
            ST_DATA: if (carrier_end) state_nxt = ST_HOLD;
            // Leaving mid-carrier must not lock onto the frame's tail
            ST_HOLD: begin
                if (rx_ack)
                    state_nxt = (carrier || carrier_start) ? ST_SKIP : ST_IDLE;
            end
            ST_SKIP: if (carrier_end) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge eth_clk or negedge eth_rstn) begin
        if (!eth_rstn) begin
            pre_cnt   <= '0;
            prev_bit  <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
            wr_ptr    <= '0;
            ovf       <= 1'b0;
            frame_len <= '0;
            frame_err <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            if (state == ST_IDLE && bit_valid) begin
                pre_cnt  <= PW'(1);
                prev_bit <= rx_bit;
            end
            if (state == ST_PRE && bit_valid) begin
                prev_bit <= rx_bit;
                if (rx_bit != prev_bit) begin
                    if (pre_cnt != PW'(MIN_PRE))
                        pre_cnt <= pre_cnt + PW'(1);
                end else begin
                    pre_cnt <= PW'(1);
                end
                if (sfd_hit) begin
                    bit_cnt <= '0;
                    wr_ptr  <= '0;
                    ovf     <= 1'b0;
                end
            end
            if (state == ST_DATA) begin
                if (bit_valid) begin
                    shreg   <= byte_nxt;
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (byte_done) begin
                    if (wr_ptr[AW]) ovf    <= 1'b1;
                    else            wr_ptr <= wr_ptr + (AW+1)'(1);
                end
                if (carrier_end) begin
                    frame_len <= wr_ptr;
                    frame_err <= err_nxt;
                end
            end
            if (state == ST_HOLD && carrier_start && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

    always_ff @(posedge eth_clk) begin
        if (byte_done && !wr_ptr[AW])
            mem[wr_ptr[AW-1:0]] <= byte_nxt;
    end

    always_ff @(posedge eth_clk or negedge eth_rstn) begin
        if (!eth_rstn) rd_data <= '0;
        else           rd_data <= mem[rd_addr];
    end

`ifdef SM_ETH_RX_CRC_EN
    logic [31:0] crc;
    logic        crc_good;

    always_ff @(posedge eth_clk or negedge eth_rstn) begin
        if (!eth_rstn) begin
            crc      <= CRC_INIT;
            crc_good <= 1'b0;
        end else begin
            if (state == ST_PRE && sfd_hit)
                crc <= CRC_INIT;
            if (state == ST_DATA && bit_valid)
                crc <= crc_step(crc, rx_bit);
            if (state == ST_DATA && carrier_end)
                crc_good <= (crc == CRC_RESIDUE) && !err_nxt;
        end
    end

    assign crc_ok = frame_ready && crc_good;
`else
    assign crc_ok = frame_ready;
`endif

endmodule

// File: tb/tb_sm_eth_rx.sv
// Directed bench for sm_eth_rx: Manchester frames driven on Rxd,
// buffer, handshake, drop counter and (with SM_ETH_RX_CRC_EN) FCS.
module tb_sm_eth_rx;
    import sm_eth_rx_pkg::*;

    localparam int OS    = 8;
    localparam int DEPTH = 128;
`ifdef SM_ETH_RX_CRC_EN
    localparam logic CRC_ON = 1'b1;
`else
    localparam logic CRC_ON = 1'b0;
`endif

    logic       eth_clk  = 1'b0;
    logic       eth_rstn = 1'b0;
    logic       Rxd      = 1'b0;
    logic       rx_ack   = 1'b0;
    logic [6:0] rd_addr  = '0;
    logic [7:0] rd_data;
    logic       frame_ready;
    logic [7:0] frame_len;
    logic       frame_err;
    logic       crc_ok;
    logic [7:0] drop_cnt;
    logic       Led_Rx;

    logic [7:0] fb [256];
    int total = 0;
    int bad   = 0;

    sm_eth_rx dut (
        .eth_clk     (eth_clk),
        .eth_rstn    (eth_rstn),
        .Rxd         (Rxd),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_ready (frame_ready),
        .frame_len   (frame_len),
        .frame_err   (frame_err),
        .crc_ok      (crc_ok),
        .rx_ack      (rx_ack),
        .drop_cnt    (drop_cnt),
        .Led_Rx      (Led_Rx)
    );

    always #5 eth_clk = ~eth_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge eth_clk);
    endtask

    task automatic send_bit(input logic b);
        Rxd = ~b;
        tick(OS / 2);
        Rxd = b;
        tick(OS / 2);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic send_pre();
        for (int i = 0; i < 8; i++) send_byte(PRE_BYTE);
        send_byte(SFD_BYTE);
    endtask

    task automatic line_idle();
        Rxd = 1'b0;
        tick(30);
    endtask

    task automatic send_frame(input int n);
        send_pre();
        for (int i = 0; i < n; i++) send_byte(fb[i]);
        line_idle();
    endtask

    task automatic read_chk(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            rd_addr = 7'(i);
            tick(1);
            chk(tag, rd_data, fb[i]);
        end
    endtask

    task automatic ack();
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
    endtask

    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < 8; j++)
                if (c[0] ^ fb[i][j]) c = (c >> 1) ^ 32'hEDB88320;
                else                 c = c >> 1;
        return ~c;
    endfunction

    initial begin
        logic [31:0] f;

        tick(3);
        chk("rst_ready", frame_ready, 0);
        chk("rst_len",   frame_len,   0);
        chk("rst_err",   frame_err,   0);
        chk("rst_crc",   crc_ok,      0);
        chk("rst_drop",  drop_cnt,    0);
        chk("rst_led",   Led_Rx,      1);
        chk("rst_rd",    rd_data,     0);
        eth_rstn = 1'b1;
        tick(2);

        // lone link pulse
        Rxd = 1'b1;
        tick(6);
        chk("nlp_led_on", Led_Rx, 0);
        tick(2);
        line_idle();
        chk("nlp_ready", frame_ready, 0);
        chk("nlp_drop",  drop_cnt,    0);
        chk("nlp_led",   Led_Rx,      1);

        // basic frame
        fb[0] = 8'h01; fb[1] = 8'h02; fb[2] = 8'h03; fb[3] = 8'hAA;
        send_frame(4);
        chk("f1_ready", frame_ready, 1);
        chk("f1_len",   frame_len,   4);
        chk("f1_err",   frame_err,   0);
        chk("f1_crc",   crc_ok,      !CRC_ON);
        read_chk("f1_rd", 4);
        rd_addr = 7'd0;
        chk("f1_lat_old", rd_data, 8'hAA);
        tick(1);
        chk("f1_lat_new", rd_data, 8'h01);
        ack();
        chk("f1_ack", frame_ready, 0);

        // frame B dropped while A is held
        fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33; fb[3] = 8'h44;
        send_frame(4);
        chk("a_ready", frame_ready, 1);
        send_pre();
        send_byte(8'h55);
        send_byte(8'h66);
        line_idle();
        chk("b_drop",  drop_cnt,    1);
        chk("b_ready", frame_ready, 1);
        chk("b_len",   frame_len,   4);
        read_chk("a_keep", 4);
        ack();
        fb[0] = 8'hC0; fb[1] = 8'hC1; fb[2] = 8'hC2;
        send_frame(3);
        chk("c_ready", frame_ready, 1);
        chk("c_len",   frame_len,   3);
        chk("c_err",   frame_err,   0);
        read_chk("c_rd", 3);
        ack();

        // overflow
        for (int i = 0; i < 130; i++) fb[i] = 8'(i) ^ 8'h5A;
        send_frame(130);
        chk("ov_ready", frame_ready, 1);
        chk("ov_len",   frame_len,   128);
        chk("ov_err",   frame_err,   1);
        chk("ov_crc",   crc_ok,      !CRC_ON);
        read_chk("ov_rd", 128);
        ack();

        // residual bits, then ack while next frame is mid-stream
        fb[0] = 8'h10; fb[1] = 8'h20; fb[2] = 8'h30; fb[3] = 8'h40;
        send_pre();
        for (int i = 0; i < 4; i++) send_byte(fb[i]);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        line_idle();
        chk("res_len", frame_len, 4);
        chk("res_err", frame_err, 1);
        send_pre();
        send_byte(8'hB0);
        rx_ack = 1'b1;
        send_byte(8'hB1);
        rx_ack = 1'b0;
        chk("skip_mid", frame_ready, 0);
        send_byte(8'hB2);
        line_idle();
        chk("skip_ready", frame_ready, 0);
        chk("skip_drop",  drop_cnt,    2);
        chk("skip_len",   frame_len,   4);
        fb[0] = 8'hD0; fb[1] = 8'hD1;
        send_frame(2);
        chk("d_ready", frame_ready, 1);
        chk("d_len",   frame_len,   2);
        chk("d_err",   frame_err,   0);
        read_chk("d_rd", 2);
        ack();

        // 60-byte payload with FCS
        for (int i = 0; i < 60; i++) fb[i] = 8'(i * 7 + 3);
        f = fcs_of(60);
        fb[60] = f[7:0];
        fb[61] = f[15:8];
        fb[62] = f[23:16];
        fb[63] = f[31:24];
        send_frame(64);
        chk("fcs_ready", frame_ready, 1);
        chk("fcs_len",   frame_len,   64);
        chk("fcs_err",   frame_err,   0);
        chk("fcs_crc",   crc_ok,      1);
        ack();

        fb[10] = fb[10] ^ 8'h04;
        send_frame(64);
        chk("bad_err", frame_err, 0);
        chk("bad_crc", crc_ok,    !CRC_ON);
        ack();
        fb[10] = fb[10] ^ 8'h04;

        // reset mid-frame
        send_pre();
        send_byte(fb[0]);
        send_byte(fb[1]);
        eth_rstn = 1'b0;
        Rxd = 1'b0;
        tick(2);
        chk("mr_ready", frame_ready, 0);
        chk("mr_led",   Led_Rx,      1);
        eth_rstn = 1'b1;
        line_idle();
        chk("mr_idle", frame_ready, 0);
        send_frame(64);
        chk("mr_ready2", frame_ready, 1);
        chk("mr_len",    frame_len,   64);
        chk("mr_err",    frame_err,   0);
        chk("mr_crc",    crc_ok,      1);
        read_chk("mr_rd", 64);
        ack();
        chk("mr_ack", frame_ready, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sm_eth_rx.md
Name: sm_eth_rx

Overview:
10BASE-T receive path, the counterpart of the existing Manchester transmit/NLP path. It samples the raw receive line and recovers Manchester bits. It hunts the preamble and SFD, then stores frame bytes into an internal byte buffer. It presents the complete frame to the bus-side wrapper with a ready/ack handshake and ignores normal link pulses.

Parameters:
OVERSAMPLE, 8, eth_clk cycles per bit (eth_clk = 80 MHz for 10 Mb/s); even, >= 6
IDLE_TO, 12, cycles without a line edge that mark end-of-carrier
MIN_PRE, 16, alternating preamble bits required before SFD is accepted
DEPTH, 128, buffer size in bytes; power of 2
POLARITY, 0, 0: bit = line level after the mid-bit edge (IEEE); 1: inverted

Ports:
eth_clk  in  1  receive clock
eth_rstn  in  1  asynchronous active-low reset
Rxd  in  1  raw receive line, asynchronous to eth_clk
rd_addr  in  $clog2(DEPTH)  buffer read byte address
rd_data  out  8  buffer byte; registered, 1-cycle latency
frame_ready  out  1  complete frame held in buffer
frame_len  out  $clog2(DEPTH)+1  bytes stored, including FCS
frame_err  out  1  frame truncated or not byte-aligned
crc_ok  out  1  FCS check result (see Optional Feature)
rx_ack  in  1  host releases the buffer
drop_cnt  out  8  frames dropped while busy; saturates at 255
Led_Rx  out  1  active-low; 0 while carrier is present

Behaviour:
- Reset: eth_clk is the only clock; eth_rstn is asynchronous and active-low. All outputs reset to 0, except Led_Rx = 1. The FSM resets to IDLE. Buffer contents are not reset. Reset mid-frame discards the frame.
- Input path: Rxd passes through a 2-FF synchronizer. An edge is any change of the synchronized level.
- Decoder timer: saturating counter, cleared on each accepted mid-bit edge.
  - Edge with timer >= 3*OVERSAMPLE/4: accepted as mid-bit. It produces bit_valid one cycle later, with bit = level XOR POLARITY.
  - Edge with timer below that threshold: bit-boundary edge, ignored.
  - First edge after idle: always accepted.
- Carrier: active from the first accepted edge until the timer reaches IDLE_TO; carrier_end pulses then.
- FSM states: IDLE, PRE, DATA, HOLD, SKIP.
- IDLE: bit_valid -> PRE with the alternation count = 1.
- PRE:
  - Bit differs from the previous bit: count++ (saturating).
  - Two consecutive 1s with count >= MIN_PRE: SFD, -> DATA.
  - Any other repeat: count = 1.
  - carrier_end: -> IDLE silently, so NLPs and noise never raise frame_ready.
- DATA:
  - Bits assemble LSB first. Every 8th bit writes the byte at index wr_ptr, and wr_ptr++.
  - When wr_ptr == DEPTH, further bytes are discarded and an overflow flag is set.
  - carrier_end -> HOLD with frame_len = wr_ptr. frame_err = overflow OR (residual bits != 0) OR (wr_ptr == 0).
- HOLD:
  - frame_ready = 1, and frame_len, frame_err and crc_ok are stable.
  - Carrier start here increments drop_cnt; those bits are not stored.
  - rx_ack: frame_ready = 0 the next cycle, then -> SKIP if carrier is active, else -> IDLE.
- SKIP: -> IDLE on carrier_end. This prevents capturing a frame mid-stream.
- rx_ack outside HOLD is ignored.
- Buffer: written only in DATA. rd_addr may read at any time. rd_data is valid the cycle after rd_addr.

Optional Feature:
- Macro SM_ETH_RX_CRC_EN.
- Defined:
  - CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, reflected, bit-serial) is updated on each DATA bit.
  - crc_ok = 1 in HOLD iff the residue equals 0xC704DD7B and frame_err = 0.
- Undefined: the CRC logic is absent and crc_ok = frame_ready.

Decomposition:
- Package sm_eth_rx_pkg holds:
  - FSM state encoding.
  - SFD and preamble constants.
  - CRC polynomial and residue constants.
- Sub-module sm_manchester_dec: synchronizer, edge detect, decoder timer, bit_valid/bit/carrier_end outputs.

Test Plan:
1. 64 alternating bits + SFD, bytes 01 02 03 AA, line held 12+ cycles -> frame_ready=1, frame_len=4, frame_err=0. rd_addr 0..3 reads 01 02 03 AA with 1-cycle latency.
2. Single NLP (8-cycle high pulse), then idle -> frame_ready stays 0, FSM returns to IDLE, drop_cnt=0.
3. Frame A received, no ack; frame B sent -> drop_cnt=1, buffer still holds A. Assert rx_ack, send frame C -> C captured.
4. DEPTH=128, 130-byte frame -> frame_len=128, frame_err=1. Bytes 0..127 are correct.
5. 4 bytes + 3 extra bits -> frame_len=4, frame_err=1. Second case: rx_ack asserted mid-frame B -> SKIP, B not captured.
6. With SM_ETH_RX_CRC_EN: 60-byte payload + correct FCS -> crc_ok=1. One flipped payload bit -> crc_ok=0. eth_rstn pulsed mid-frame -> frame_ready=0, then the next frame is received normally.
